ntt_layer_scheduler: RTL and testbench
======================================

// Module: ntt_layer_scheduler
// PURPOSE
//  Sequencer for the in-place Kyber forward NTT (Cooley-Tukey, 7 layers x 128 butterflies).
//  It issues one butterfly per accepted beat (U/V RAM addresses plus zeta table index) to the
//  RAM + butterfly datapath over a valid/ready handshake. Between layers it inserts a drain
//  bubble so that write-backs land before the next layer reads. It sits between the top FSM
//  (start/done) and the dual-port RAM / butterfly pipeline.
// PARAMETERS
//  LOG_N       8  log2 of polynomial length (N=256); layers = LOG_N-1, beats/layer = N/2
//  PIPE_DEPTH  4  idle cycles inserted after each layer's last beat (datapath read->write latency); 0 = no bubble
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        begin a full NTT; sampled only in IDLE
//  abort        in   1        synchronous cancel; return to IDLE, no done
//  bf_ready     in   1        datapath accepts current beat
//  bf_valid     out  1        beat outputs valid
//  addr_u       out  LOG_N    RAM address of U (r[j])
//  addr_v       out  LOG_N    RAM address of V (r[j+len])
//  zeta_idx     out  LOG_N-1  zeta ROM index k (1..N/2-1)
//  layer        out  3        current layer 0..LOG_N-2
//  last_beat    out  1        current beat is last of its layer
//  busy         out  1        high from cycle after accepted start until DONE (exclusive)
//  done         out  1        one-cycle pulse at completion
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, all counters 0. Asynchronous; clears mid-operation with no done.
//  - All outputs are registered.
//  - States: IDLE -> ISSUE (start=1) -> DRAIN (last beat of a layer accepted)
//    -> ISSUE (next layer) | DONE (last layer); DONE -> IDLE after one cycle.
//  - Counters: layer l (0..LOG_N-2), beat b (0..N/2-1), drain counter d (0..PIPE_DEPTH-1).
//  - Address math (unsigned):
//      len      = N >> (l+1)
//      g        = b >> (LOG_N-1-l)
//      j        = b & (len-1)
//      addr_u   = g*2*len + j
//      addr_v   = addr_u + len
//      zeta_idx = (1<<l) + g
//  - Handshake: bf_valid=1 only in ISSUE. A beat transfers when bf_valid & bf_ready.
//    While bf_ready=0, all beat outputs hold stable. bf_valid never drops without a transfer,
//    except on abort or rst.
//  - On transfer with b < N/2-1: b++ and the next beat is presented the following cycle
//    (back-to-back, 1 beat/cycle).
//  - On transfer with b = N/2-1 (last_beat=1): b<=0, go to DRAIN. bf_valid=0 for exactly
//    PIPE_DEPTH cycles. Then l++ and ISSUE, or DONE if l = LOG_N-2.
//    If PIPE_DEPTH=0, go directly to the next ISSUE/DONE (no bubble).
//  - DONE: done=1, busy=0, bf_valid=0 for one cycle; then IDLE.
//  - start outside IDLE is ignored. start in IDLE at cycle t -> first beat presented at t+1.
//  - abort (any non-IDLE state) -> IDLE next cycle; counters cleared; bf_valid=0, busy=0, done stays 0.
//    abort has priority over a simultaneous transfer. abort in IDLE has priority over start.
//  - Latency with bf_ready=1 and defaults: done at t+1 + 7*(128+PIPE_DEPTH) = t+925.
// TESTING
//  1. start pulse, bf_ready=1 -> first beat: addr_u=0, addr_v=128, zeta=1, layer=0.
//     Beat 127: addr_u=127, addr_v=255, last_beat=1. Then 4 cycles with bf_valid=0.
//  2. Layer 1 -> b=0: 0/64, zeta=2. b=64: 128/192, zeta=3.
//     Layer 6, b=127: addr_u=253, addr_v=255, zeta=127, last_beat=1.
//     done at t+925; exactly 896 transfers; every address appears 7 times as U or V.
//  3. bf_ready=0 for 5 cycles at layer 2, b=10 -> outputs frozen (addr_u=10, addr_v=42, zeta=4);
//     resumes at b=11; done delayed by exactly 5 cycles.
//  4. start re-asserted while busy -> ignored; sequence and done time unchanged.
//     start after done -> new full run.
//  5. abort at layer 3, b=50 together with bf_ready=1 -> next cycle IDLE, bf_valid=0, busy=0,
//     no done; subsequent start restarts at 0/128/zeta=1.
//  6. rst asserted asynchronously mid-DRAIN -> outputs 0 immediately. PIPE_DEPTH=0 build ->
//     layers back-to-back, done at t+897.

Source files
------------

// File: rtl/ntt_layer_scheduler.sv
// ntt_layer_scheduler
// Beat sequencer for the in-place Kyber forward NTT (Cooley-Tukey, LOG_N-1 layers of N/2
// butterflies). Each accepted beat carries the U/V RAM addresses, the zeta ROM index and
// the layer number. After the last beat of a layer the scheduler idles PIPE_DEPTH cycles
// so the datapath can write results back before the next layer reads them.
// Every output comes straight from a flop. The flops load values computed from the next
// layer/beat counters, so the outputs always describe the beat currently on offer.
module ntt_layer_scheduler #(
   parameter int LOG_N      = 8,
   parameter int PIPE_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             bf_ready_i,
   output logic             bf_valid_o,
   output logic [LOG_N-1:0] addr_u_o,
   output logic [LOG_N-1:0] addr_v_o,
   output logic [LOG_N-2:0] zeta_idx_o,
   output logic [2:0]       layer_o,
   output logic             last_beat_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int HALF = 1 << (LOG_N - 1);
   localparam int DW   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   localparam logic [LOG_N-2:0] B_LAST    = (LOG_N-1)'(HALF - 1);
   localparam logic [2:0]       L_LAST    = 3'(LOG_N - 2);
   localparam logic [DW-1:0]    D_LAST    = DW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);
   localparam bit               HAS_DRAIN = (PIPE_DEPTH > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       layer_q, layer_d;
   logic [LOG_N-2:0] beat_q,  beat_d;
   logic [DW-1:0]    drain_q, drain_d;

   logic             valid_q,  valid_d;
   logic [LOG_N-1:0] addr_u_q, addr_u_d;
   logic [LOG_N-1:0] addr_v_q, addr_v_d;
   logic [LOG_N-2:0] zeta_q,   zeta_d;
   logic [2:0]       lay_o_q,  lay_o_d;
   logic             last_q,   last_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   // Butterfly half-distance of layer l: len = N >> (l+1).
   function automatic logic [LOG_N-1:0] calc_len(input logic [2:0] l);
      return LOG_N'(HALF) >> l;
   endfunction

   // Butterfly group of beat b in layer l: g = b >> (LOG_N-1-l).
   function automatic logic [LOG_N-1:0] calc_group(input logic [2:0] l,
                                                   input logic [LOG_N-2:0] b);
      return {1'b0, b} >> (4'(LOG_N - 1) - {1'b0, l});
   endfunction

   // U address: g*2*len + j, where 2*len = N >> l and j = b mod len.
   function automatic logic [LOG_N-1:0] calc_addr_u(input logic [2:0] l,
                                                    input logic [LOG_N-2:0] b);
      logic [LOG_N-1:0] g;
      logic [LOG_N-1:0] j;
      g = calc_group(l, b);
      j = {1'b0, b} & (calc_len(l) - LOG_N'(1));
      return (g << (4'(LOG_N) - {1'b0, l})) + j;
   endfunction

   // V address sits len words above U.
   function automatic logic [LOG_N-1:0] calc_addr_v(input logic [2:0] l,
                                                    input logic [LOG_N-2:0] b);
      return calc_addr_u(l, b) + calc_len(l);
   endfunction

   // Zeta ROM index: layer l uses entries 2^l .. 2^(l+1)-1, one per group.
   function automatic logic [LOG_N-2:0] calc_zeta(input logic [2:0] l,
                                                  input logic [LOG_N-2:0] b);
      return (LOG_N-1)'((LOG_N'(1) << l) + calc_group(l, b));
   endfunction

   // Sequencer state and counters; async reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         layer_q <= 3'd0;
         beat_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         beat_q  <= beat_d;
         drain_q <= drain_d;
      end
   end

   // Next-state and counter logic. abort wins over start and over a concurrent transfer.
   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
               layer_d = 3'd0;
               beat_d  = '0;
               drain_d = '0;
            end else if (start_i) begin
               state_d = ST_ISSUE;
               layer_d = 3'd0;
               beat_d  = '0;
               drain_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
               layer_d = 3'd0;
               beat_d  = '0;
               drain_d = '0;
            end else if (bf_ready_i) begin
               if (beat_q == B_LAST) begin
                  beat_d  = '0;
                  drain_d = '0;
                  if (HAS_DRAIN) begin
                     state_d = ST_DRAIN;
                  end else if (layer_q == L_LAST) begin
                     state_d = ST_DONE;
                     layer_d = 3'd0;
                  end else begin
                     state_d = ST_ISSUE;
                     layer_d = layer_q + 3'd1;
                  end
               end else begin
                  beat_d = beat_q + (LOG_N-1)'(1);
               end
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (abort_i) begin
               state_d = ST_IDLE;
               layer_d = 3'd0;
               beat_d  = '0;
               drain_d = '0;
            end else if (drain_q == D_LAST) begin
               drain_d = '0;
               if (layer_q == L_LAST) begin
                  state_d = ST_DONE;
                  layer_d = 3'd0;
               end else begin
                  state_d = ST_ISSUE;
                  layer_d = layer_q + 3'd1;
               end
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            layer_d = 3'd0;
            beat_d  = '0;
            drain_d = '0;
         end
         default: begin
            state_d = ST_IDLE;
            layer_d = 3'd0;
            beat_d  = '0;
            drain_d = '0;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state and counters.
   always_comb begin
      valid_d  = 1'b0;
      addr_u_d = '0;
      addr_v_d = '0;
      zeta_d   = '0;
      lay_o_d  = 3'd0;
      last_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      if (state_d == ST_ISSUE) begin
         valid_d  = 1'b1;
         addr_u_d = calc_addr_u(layer_d, beat_d);
         addr_v_d = calc_addr_v(layer_d, beat_d);
         zeta_d   = calc_zeta(layer_d, beat_d);
         last_d   = (beat_d == B_LAST);
      end else begin
         valid_d  = 1'b0;
      end
      if ((state_d == ST_ISSUE) || (state_d == ST_DRAIN)) begin
         lay_o_d = layer_d;
         busy_d  = 1'b1;
      end else begin
         busy_d  = 1'b0;
      end
      if (state_d == ST_DONE) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         addr_u_q <= '0;
         addr_v_q <= '0;
         zeta_q   <= '0;
         lay_o_q  <= 3'd0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         addr_u_q <= addr_u_d;
         addr_v_q <= addr_v_d;
         zeta_q   <= zeta_d;
         lay_o_q  <= lay_o_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bf_valid_o  = valid_q;
   assign addr_u_o    = addr_u_q;
   assign addr_v_o    = addr_v_q;
   assign zeta_idx_o  = zeta_q;
   assign layer_o     = lay_o_q;
   assign last_beat_o = last_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// Bench for ntt_layer_scheduler: a beat-list reference (classic Kyber NTT loops) plus a
// cycle model stepped on inputs, checked every cycle, and directed literal expectations.
module tb_ntt_layer_scheduler;

   localparam int LOG_N = 8;
   localparam int PD    = 4;
   localparam int N     = 256;
   localparam int HALF  = 128;
   localparam int TOTAL = 896;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_i = 1'b0, start0_i = 1'b0, abort_i = 1'b0, bf_ready_i = 1'b0;

   logic             bf_valid_o, last_beat_o, busy_o, done_o;
   logic [LOG_N-1:0] addr_u_o, addr_v_o;
   logic [LOG_N-2:0] zeta_idx_o;
   logic [2:0]       layer_o;

   logic             bf_valid0, last_beat0, busy0, done0;
   logic [LOG_N-1:0] addr_u0, addr_v0;
   logic [LOG_N-2:0] zeta_idx0;
   logic [2:0]       layer0;

   ntt_layer_scheduler #(.LOG_N(LOG_N), .PIPE_DEPTH(PD)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .bf_ready_i(bf_ready_i),
      .bf_valid_o(bf_valid_o), .addr_u_o(addr_u_o), .addr_v_o(addr_v_o),
      .zeta_idx_o(zeta_idx_o), .layer_o(layer_o), .last_beat_o(last_beat_o),
      .busy_o(busy_o), .done_o(done_o));

   ntt_layer_scheduler #(.LOG_N(LOG_N), .PIPE_DEPTH(0)) dut0 (
      .clk(clk), .rst(rst), .start_i(start0_i), .abort_i(abort_i), .bf_ready_i(bf_ready_i),
      .bf_valid_o(bf_valid0), .addr_u_o(addr_u0), .addr_v_o(addr_v0),
      .zeta_idx_o(zeta_idx0), .layer_o(layer0), .last_beat_o(last_beat0),
      .busy_o(busy0), .done_o(done0));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference beat list from the textbook in-place NTT loops.
   int ref_u[TOTAL];
   int ref_v[TOTAL];
   int ref_z[TOTAL];

   task automatic build_table();
      int k = 1;
      int p = 0;
      for (int len = HALF; len >= 2; len = len / 2) begin
         for (int st = 0; st < N; st = st + 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               ref_u[p] = j;
               ref_v[p] = j + len;
               ref_z[p] = k;
               p++;
            end
            k++;
         end
      end
   endtask

   // Cycle model: position in the beat list, remaining bubble cycles, done pulse.
   int m_pos = 0;
   int m_bubble = 0;
   bit m_run = 1'b0;
   bit m_done = 1'b0;
   bit m_ev;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 1'b0; m_done = 1'b0; m_pos = 0; m_bubble = 0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (!m_run) begin
         if (start_i && !abort_i) begin
            m_run = 1'b1; m_pos = 0; m_bubble = 0;
         end
      end else if (abort_i) begin
         m_run = 1'b0; m_pos = 0; m_bubble = 0;
      end else if (m_bubble > 0) begin
         m_bubble--;
         if (m_bubble == 0 && m_pos == TOTAL) begin
            m_run = 1'b0; m_done = 1'b1;
         end
      end else if (bf_ready_i) begin
         m_pos++;
         if (m_pos % HALF == 0) m_bubble = PD;
      end
   end

   // Compare the DUT against the model every cycle.
   always @(negedge clk) begin
      m_ev = m_run && (m_bubble == 0) && (m_pos < TOTAL);
      chk("bf_valid", int'(bf_valid_o), int'(m_ev));
      chk("busy", int'(busy_o), int'(m_run));
      chk("done", int'(done_o), int'(m_done));
      if (m_ev) begin
         chk("addr_u", int'(addr_u_o), ref_u[m_pos]);
         chk("addr_v", int'(addr_v_o), ref_v[m_pos]);
         chk("zeta_idx", int'(zeta_idx_o), ref_z[m_pos]);
         chk("layer", int'(layer_o), m_pos / HALF);
         chk("last_beat", int'(last_beat_o), int'(m_pos % HALF == HALF - 1));
      end else begin
         chk("last_beat_idle", int'(last_beat_o), 0);
      end
   end

   // Transfer monitors (outputs read before this edge's update).
   int cyc = 0;
   int xfers = 0, xfers0 = 0, bub0 = 0;
   int hist[N];
   always @(posedge clk) begin
      cyc++;
      if (!rst && bf_valid_o && bf_ready_i) begin
         xfers++;
         hist[addr_u_o]++;
         hist[addr_v_o]++;
      end
      if (!rst && bf_valid0 && bf_ready_i) xfers0++;
      if (!rst && busy0 && !bf_valid0) bub0++;
   end

   int e0 = 0;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      start_i = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_off);
      int k = 0;
      while (done_o !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk(name, cyc - e0, exp_off);
   endtask

   task automatic chk_beat(input string name, input int u, input int v, input int z, input int l);
      chk({name, "_valid"}, int'(bf_valid_o), 1);
      chk({name, "_u"}, int'(addr_u_o), u);
      chk({name, "_v"}, int'(addr_v_o), v);
      chk({name, "_zeta"}, int'(zeta_idx_o), z);
      chk({name, "_layer"}, int'(layer_o), l);
   endtask

   initial begin
      int bad;
      build_table();
      // literal pins on the reference list itself
      chk("ref_first", ref_u[0] * 1000 + ref_v[0] * 10 + ref_z[0], 128 * 10 + 1);
      chk("ref_l6_last", ref_u[895] * 1000 + ref_v[895], 253 * 1000 + 255);
      chk("ref_l6_zeta", ref_z[895], 127);

      // reset state
      step(2);
      chk("rst_valid", int'(bf_valid_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_addr", int'(addr_u_o) + int'(addr_v_o) + int'(zeta_idx_o) + int'(layer_o), 0);
      rst = 1'b0;
      bf_ready_i = 1'b1;
      step(2);

      // full run with literal beats and transfer statistics
      xfers = 0;
      for (int i = 0; i < N; i++) hist[i] = 0;
      do_start();
      chk_beat("t1_first", 0, 128, 1, 0);
      step(127);
      chk_beat("t1_b127", 127, 255, 1, 0);
      chk("t1_b127_last", int'(last_beat_o), 1);
      step(1);
      chk("t1_drain0", int'(bf_valid_o), 0);
      step(3);
      chk("t1_drain3", int'(bf_valid_o), 0);
      step(1);
      chk_beat("t2_l1_b0", 0, 64, 2, 1);
      step(64);
      chk_beat("t2_l1_b64", 128, 192, 3, 1);
      step(723);
      chk_beat("t2_l6_b127", 253, 255, 127, 6);
      chk("t2_l6_last", int'(last_beat_o), 1);
      wait_done("t2_done_time", 924);
      chk("t2_xfers", xfers, TOTAL);
      bad = 0;
      for (int i = 0; i < N; i++) if (hist[i] != 7) bad++;
      chk("t2_addr_hist", bad, 0);
      step(1);
      chk("t2_idle_busy", int'(busy_o), 0);

      // backpressure at layer 2, beat 10
      step(2);
      do_start();
      step(274);
      chk_beat("t3_b10", 10, 42, 4, 2);
      bf_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk_beat("t3_frozen", 10, 42, 4, 2);
      end
      bf_ready_i = 1'b1;
      step(1);
      chk_beat("t3_b11", 11, 43, 4, 2);
      wait_done("t3_done_time", 929);

      // start while busy is ignored; start after done restarts
      step(2);
      do_start();
      step(300);
      start_i = 1'b1; step(1); start_i = 1'b0;
      step(50);
      start_i = 1'b1; step(1); start_i = 1'b0;
      wait_done("t4_done_time", 924);
      step(2);
      do_start();
      chk_beat("t4_restart", 0, 128, 1, 0);
      abort_i = 1'b1; step(1); abort_i = 1'b0;

      // abort at layer 3, beat 50 with a concurrent transfer
      step(2);
      do_start();
      step(446);
      chk_beat("t5_b50", 98, 114, 11, 3);
      abort_i = 1'b1;
      step(1);
      abort_i = 1'b0;
      chk("t5_valid", int'(bf_valid_o), 0);
      chk("t5_busy", int'(busy_o), 0);
      step(10);
      chk("t5_no_done", int'(done_o), 0);
      do_start();
      chk_beat("t5_restart", 0, 128, 1, 0);
      abort_i = 1'b1; step(1); abort_i = 1'b0;
      // abort in IDLE beats start
      start_i = 1'b1; abort_i = 1'b1; step(1); start_i = 1'b0; abort_i = 1'b0;
      chk("t5_idle_abort_busy", int'(busy_o), 0);

      // async reset during drain
      step(2);
      do_start();
      step(128);
      chk("t6_in_drain", int'(busy_o) * 2 + int'(bf_valid_o), 2);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_busy", int'(busy_o), 0);
      chk("t6_rst_valid", int'(bf_valid_o), 0);
      chk("t6_rst_outs", int'(addr_u_o) + int'(addr_v_o) + int'(zeta_idx_o) + int'(layer_o)
                         + int'(last_beat_o) + int'(done_o), 0);
      @(negedge clk);
      rst = 1'b0;
      step(10);

      // PIPE_DEPTH = 0 build: no bubbles, done 896 cycles after the first beat edge
      xfers0 = 0;
      bub0 = 0;
      start0_i = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start0_i = 1'b0;
      chk("t6b_first", int'(addr_u0) * 1000 + int'(addr_v0) * 10 + int'(bf_valid0), 1281);
      step(128);
      chk("t6b_l1_b0", int'(addr_u0) * 1000 + int'(addr_v0) * 10 + int'(bf_valid0), 641);
      chk("t6b_l1_zeta", int'(zeta_idx0), 2);
      chk("t6b_l1_layer", int'(layer0), 1);
      begin
         int k = 0;
         while (done0 !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
         end
      end
      chk("t6b_done_time", cyc - e0, 896);
      chk("t6b_xfers", xfers0, TOTAL);
      chk("t6b_bubbles", bub0, 0);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
